// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decodes RV32I OP / OP-IMM instructions into ALU operands and a
// 4-bit function code, and hands them to the ALU through a registered valid/ready
// interface backed by a two-entry (main + skid) buffer.
//
// Optional feature macro: ALU_OPERAND_UPPER_EN
//   defined     -> LUI and AUIPC are decoded (Function=add, RHS = U-immediate)
//   not defined -> LUI and AUIPC are flagged Illegal like any other unsupported opcode
module alu_operand_stage (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] Instruction,
    input  logic [31:0] PC,
    input  logic [31:0] RS1Data,
    input  logic [31:0] RS2Data,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] LHS,
    output logic [31:0] RHS,
    output logic [3:0]  Function,
    output logic [4:0]  Rd,
    output logic        Illegal
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
`ifdef ALU_OPERAND_UPPER_EN
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
`endif

    localparam logic [6:0] Funct7Zero = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    localparam logic [2:0] F3Add = 3'b000;
    localparam logic [2:0] F3Sll = 3'b001;
    localparam logic [2:0] F3Srx = 3'b101;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    assign opcode   = Instruction[6:0];
    assign funct3   = Instruction[14:12];
    assign funct7   = Instruction[31:25];
    assign rd_field = Instruction[11:7];
    assign imm_i    = {{20{Instruction[31]}}, Instruction[31:20]};
    assign imm_u    = {Instruction[31:12], 12'b0};

    // ------------------------------------------------------------------
    // Decoded entry (combinational, input side)
    // ------------------------------------------------------------------
    logic [31:0] dec_lhs;
    logic [31:0] dec_rhs;
    logic [3:0]  dec_func;
    logic [4:0]  dec_rd;
    logic        dec_illegal;

    // Decode OP / OP-IMM (and optionally LUI/AUIPC); illegal encodings yield all-zero fields.
    always_comb begin
        dec_lhs     = 32'b0;
        dec_rhs     = 32'b0;
        dec_func    = 4'b0000;
        dec_rd      = 5'b0;
        dec_illegal = 1'b1;

        unique case (opcode)
            OpcOp: begin
                // Only SUB and SRA may use the alternate funct7.
                if ((funct7 == Funct7Zero) ||
                    ((funct7 == Funct7Alt) && ((funct3 == F3Add) || (funct3 == F3Srx)))) begin
                    dec_illegal = 1'b0;
                    dec_lhs     = RS1Data;
                    dec_rhs     = RS2Data;
                    dec_func    = {Instruction[30], funct3};
                    dec_rd      = rd_field;
                end
            end

            OpcOpImm: begin
                unique case (funct3)
                    F3Sll:   dec_illegal = (funct7 != Funct7Zero);
                    F3Srx:   dec_illegal = !((funct7 == Funct7Zero) || (funct7 == Funct7Alt));
                    default: dec_illegal = 1'b0;
                endcase
                if (!dec_illegal) begin
                    dec_lhs  = RS1Data;
                    dec_rhs  = imm_i;
                    // Bit 30 selects SRAI only; for other immediates it is just an imm bit.
                    dec_func = {(funct3 == F3Srx) ? Instruction[30] : 1'b0, funct3};
                    dec_rd   = rd_field;
                end
            end

`ifdef ALU_OPERAND_UPPER_EN
            OpcLui: begin
                dec_illegal = 1'b0;
                dec_lhs     = 32'b0;
                dec_rhs     = imm_u;
                dec_func    = 4'b0000;
                dec_rd      = rd_field;
            end

            OpcAuipc: begin
                dec_illegal = 1'b0;
                dec_lhs     = PC;
                dec_rhs     = imm_u;
                dec_func    = 4'b0000;
                dec_rd      = rd_field;
            end
`endif

            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Main and skid registers
    // ------------------------------------------------------------------
    logic        main_valid_q, main_valid_d;
    logic [31:0] main_lhs_q,   main_lhs_d;
    logic [31:0] main_rhs_q,   main_rhs_d;
    logic [3:0]  main_func_q,  main_func_d;
    logic [4:0]  main_rd_q,    main_rd_d;
    logic        main_ill_q,   main_ill_d;

    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_lhs_q,   skid_lhs_d;
    logic [31:0] skid_rhs_q,   skid_rhs_d;
    logic [3:0]  skid_func_q,  skid_func_d;
    logic [4:0]  skid_rd_q,    skid_rd_d;
    logic        skid_ill_q,   skid_ill_d;

    logic        in_ready_q,   in_ready_d;

    logic        accept;
    logic        drain;

    assign accept = InValid & in_ready_q;
    assign drain  = main_valid_q & OutReady;

    // Next-state: route accepted entries into main or skid, refill main from skid on drain.
    always_comb begin
        main_valid_d = main_valid_q;
        main_lhs_d   = main_lhs_q;
        main_rhs_d   = main_rhs_q;
        main_func_d  = main_func_q;
        main_rd_d    = main_rd_q;
        main_ill_d   = main_ill_q;

        skid_valid_d = skid_valid_q;
        skid_lhs_d   = skid_lhs_q;
        skid_rhs_d   = skid_rhs_q;
        skid_func_d  = skid_func_q;
        skid_rd_d    = skid_rd_q;
        skid_ill_d   = skid_ill_q;

        if (drain) begin
            if (skid_valid_q) begin
                // Skid full implies in_ready_q=0, so no accept can collide with this move.
                main_valid_d = 1'b1;
                main_lhs_d   = skid_lhs_q;
                main_rhs_d   = skid_rhs_q;
                main_func_d  = skid_func_q;
                main_rd_d    = skid_rd_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_lhs_d   = dec_lhs;
                main_rhs_d   = dec_rhs;
                main_func_d  = dec_func;
                main_rd_d    = dec_rd;
                main_ill_d   = dec_illegal;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_lhs_d   = dec_lhs;
                main_rhs_d   = dec_rhs;
                main_func_d  = dec_func;
                main_rd_d    = dec_rd;
                main_ill_d   = dec_illegal;
            end else begin
                // Main is stalled: park the new entry so upstream is not blocked this cycle.
                skid_valid_d = 1'b1;
                skid_lhs_d   = dec_lhs;
                skid_rhs_d   = dec_rhs;
                skid_func_d  = dec_func;
                skid_rd_d    = dec_rd;
                skid_ill_d   = dec_illegal;
            end
        end

        // Ready depends only on the next registered skid state, never on OutReady directly.
        in_ready_d = !skid_valid_d;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            main_valid_q <= 1'b0;
            main_lhs_q   <= 32'b0;
            main_rhs_q   <= 32'b0;
            main_func_q  <= 4'b0;
            main_rd_q    <= 5'b0;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_lhs_q   <= 32'b0;
            skid_rhs_q   <= 32'b0;
            skid_func_q  <= 4'b0;
            skid_rd_q    <= 5'b0;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_lhs_q   <= main_lhs_d;
            main_rhs_q   <= main_rhs_d;
            main_func_q  <= main_func_d;
            main_rd_q    <= main_rd_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_lhs_q   <= skid_lhs_d;
            skid_rhs_q   <= skid_rhs_d;
            skid_func_q  <= skid_func_d;
            skid_rd_q    <= skid_rd_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Outputs come straight from registered state.
    assign InReady  = in_ready_q;
    assign OutValid = main_valid_q;
    assign LHS      = main_lhs_q;
    assign RHS      = main_rhs_q;
    assign Function = main_func_q;
    assign Rd       = main_rd_q;
    assign Illegal  = main_ill_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: table of single-instruction decode vectors plus
// hand-written backpressure, throughput and mid-operation reset sequences.
module tb_alu_operand_stage;

    logic        Clock;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instruction;
    logic [31:0] PC;
    logic [31:0] RS1Data;
    logic [31:0] RS2Data;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] LHS;
    logic [31:0] RHS;
    logic [3:0]  Function;
    logic [4:0]  Rd;
    logic        Illegal;

    int unsigned n_cmp;
    int unsigned n_bad;

    alu_operand_stage dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .InValid     (InValid),
        .InReady     (InReady),
        .Instruction (Instruction),
        .PC          (PC),
        .RS1Data     (RS1Data),
        .RS2Data     (RS2Data),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .LHS         (LHS),
        .RHS         (RHS),
        .Function    (Function),
        .Rd          (Rd),
        .Illegal     (Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    localparam int NVec = 15;
    vec_t vecs [NVec];

    function automatic vec_t mk(string name, logic [31:0] instr, logic [31:0] pc,
                                logic [31:0] rs1, logic [31:0] rs2, logic [31:0] lhs,
                                logic [31:0] rhs, logic [3:0] func, logic [4:0] rd,
                                logic ill);
        vec_t v;
        v.name = name; v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.lhs = lhs; v.rhs = rhs; v.func = func; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_out(string tag, logic v, logic [31:0] lhs, logic [31:0] rhs,
                             logic [3:0] func, logic [4:0] rd, logic ill);
        check({tag, ".OutValid"}, {31'b0, OutValid}, {31'b0, v});
        check({tag, ".LHS"}, LHS, lhs);
        check({tag, ".RHS"}, RHS, rhs);
        check({tag, ".Function"}, {28'b0, Function}, {28'b0, func});
        check({tag, ".Rd"}, {27'b0, Rd}, {27'b0, rd});
        check({tag, ".Illegal"}, {31'b0, Illegal}, {31'b0, ill});
    endtask

    // ADDI rd, x0, imm : convenient tagged entries for ordering tests
    function automatic logic [31:0] addi(logic [4:0] rd, logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic drive(logic [31:0] instr, logic [31:0] rs1);
        Instruction = instr;
        PC          = 32'h0;
        RS1Data     = rs1;
        RS2Data     = 32'h0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = mk("add",    32'h002081B3, 0, 5, 7, 5, 7, 4'b0000, 3, 0);
        vecs[1]  = mk("srai",   32'h40335293, 0, 32'h80000000, 0, 32'h80000000,
                      32'h00000403, 4'b1101, 5, 0);
        vecs[2]  = mk("addi_m1", 32'hFFF00093, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b0000, 1, 0);
        vecs[3]  = mk("sub",    32'h40208233, 0, 10, 3, 10, 3, 4'b1000, 4, 0);
        vecs[4]  = mk("sra",    32'h4083D333, 0, 32'hF0F0F0F0, 4, 32'hF0F0F0F0, 4,
                      4'b1101, 6, 0);
        vecs[5]  = mk("bad_opc", 32'h0000007F, 0, 9, 9, 0, 0, 4'b0000, 0, 1);
        vecs[6]  = mk("or_alt", 32'h4020E1B3, 0, 9, 9, 0, 0, 4'b0000, 0, 1);
        vecs[7]  = mk("sltiu",  32'hFFB1B113, 0, 32'h1234, 0, 32'h1234, 32'hFFFFFFFB,
                      4'b0011, 2, 0);
        vecs[8]  = mk("slli_bad", 32'h02309113, 0, 1, 0, 0, 0, 4'b0000, 0, 1);
        vecs[9]  = mk("andi_b30", 32'h4000F193, 0, 32'hFFFF, 0, 32'hFFFF, 32'h400,
                      4'b0111, 3, 0);
        vecs[10] = mk("slt",    32'h0020A2B3, 0, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1,
                      4'b0010, 5, 0);
        vecs[11] = mk("xor_alt", 32'h4020C2B3, 0, 3, 4, 0, 0, 4'b0000, 0, 1);
        vecs[12] = mk("srli",   32'h01F15093, 0, 32'h80000000, 0, 32'h80000000, 32'h1F,
                      4'b0101, 1, 0);
`ifdef ALU_OPERAND_UPPER_EN
        vecs[13] = mk("lui",    32'h123450B7, 32'h1000, 7, 7, 0, 32'h12345000, 4'b0000, 1, 0);
        vecs[14] = mk("auipc",  32'hABCDE117, 32'h1000, 7, 7, 32'h1000, 32'hABCDE000,
                      4'b0000, 2, 0);
`else
        vecs[13] = mk("lui",    32'h123450B7, 32'h1000, 7, 7, 0, 0, 4'b0000, 0, 1);
        vecs[14] = mk("auipc",  32'hABCDE117, 32'h1000, 7, 7, 0, 0, 4'b0000, 0, 1);
`endif

        // ---------------- reset ----------------
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        Instruction = 0; PC = 0; RS1Data = 0; RS2Data = 0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        check("reset.InReady", {31'b0, InReady}, 32'd1);
        check_out("reset", 0, 0, 0, 4'b0000, 0, 0);

        // ---------------- table-driven decode ----------------
        for (int i = 0; i < NVec; i++) begin
            @(negedge Clock);
            Instruction = vecs[i].instr;
            PC          = vecs[i].pc;
            RS1Data     = vecs[i].rs1;
            RS2Data     = vecs[i].rs2;
            InValid     = 1'b1;
            OutReady    = 1'b1;
            @(posedge Clock);
            @(negedge Clock);
            InValid = 1'b0;
            check_out(vecs[i].name, 1, vecs[i].lhs, vecs[i].rhs, vecs[i].func,
                      vecs[i].rd, vecs[i].ill);
        end
        @(negedge Clock);
        check("idle.OutValid", {31'b0, OutValid}, 32'd0);

        // ---------------- backpressure: A, B, C with OutReady=0 ----------------
        OutReady = 1'b0;
        drive(addi(5'd10, 12'h00A), 32'h0); InValid = 1'b1;
        @(posedge Clock); @(negedge Clock);
        check("bp.A_inready", {31'b0, InReady}, 32'd1);
        check_out("bp.A", 1, 0, 32'h0A, 4'b0000, 10, 0);
        drive(addi(5'd11, 12'h00B), 32'h0);
        @(posedge Clock); @(negedge Clock);
        check("bp.B_inready", {31'b0, InReady}, 32'd0);
        check_out("bp.hold1", 1, 0, 32'h0A, 4'b0000, 10, 0);
        drive(addi(5'd12, 12'h00C), 32'h0);
        @(posedge Clock); @(negedge Clock);
        check("bp.C_blocked", {31'b0, InReady}, 32'd0);
        check_out("bp.hold2", 1, 0, 32'h0A, 4'b0000, 10, 0);
        OutReady = 1'b1;
        @(posedge Clock); @(negedge Clock);
        check("bp.ready_after_drain", {31'b0, InReady}, 32'd1);
        check_out("bp.B", 1, 0, 32'h0B, 4'b0000, 11, 0);
        @(posedge Clock); @(negedge Clock);
        InValid = 1'b0;
        check_out("bp.C", 1, 0, 32'h0C, 4'b0000, 12, 0);
        @(posedge Clock); @(negedge Clock);
        check("bp.empty", {31'b0, OutValid}, 32'd0);

        // ---------------- throughput: one per cycle ----------------
        OutReady = 1'b1;
        InValid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(addi(5'(20 + k), 12'(k + 1)), 32'h0);
            @(posedge Clock); @(negedge Clock);
            check("tp.InReady", {31'b0, InReady}, 32'd1);
            check_out("tp", 1, 0, 32'(k + 1), 4'b0000, 5'(20 + k), 0);
        end
        InValid = 1'b0;
        @(posedge Clock); @(negedge Clock);
        check("tp.empty", {31'b0, OutValid}, 32'd0);

        // ---------------- reset with both entries full ----------------
        OutReady = 1'b0;
        InValid  = 1'b1;
        drive(addi(5'd7, 12'h077), 32'h0);
        @(posedge Clock); @(negedge Clock);
        drive(addi(5'd8, 12'h088), 32'h0);
        @(posedge Clock); @(negedge Clock);
        check("rst.full_inready", {31'b0, InReady}, 32'd0);
        Reset    = 1'b1;
        OutReady = 1'b1;
        @(posedge Clock); @(negedge Clock);
        Reset   = 1'b0;
        InValid = 1'b0;
        check("rst.InReady", {31'b0, InReady}, 32'd1);
        check_out("rst", 0, 0, 0, 4'b0000, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock); @(negedge Clock);
            check("rst.no_stale", {31'b0, OutValid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline stage directly upstream of the RV32I integer ALU. Accepts a fetched instruction with its PC and register-file read data, decodes OP / OP-IMM integer instructions into the ALU's 4-bit function code and its LHS/RHS operands, and presents them to the ALU through a registered valid/ready interface. A two-entry skid buffer gives full throughput under backpressure. Unsupported encodings are flagged, not dropped.

## Interface
Parameters:
- none

Ports:
- Clock  in  1  single clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high
- InValid  in  1  upstream has an instruction
- InReady  out  1  stage can accept; registered
- Instruction  in  32  raw RV32I instruction word
- PC  in  32  address of Instruction
- RS1Data  in  32  register-file value for Instruction[19:15]
- RS2Data  in  32  register-file value for Instruction[24:20]
- OutValid  out  1  LHS/RHS/Function/Rd/Illegal valid
- OutReady  in  1  downstream consumes this cycle
- LHS  out  32  ALU left operand
- RHS  out  32  ALU right operand
- Function  out  4  ALU function code
- Rd  out  5  destination register, Instruction[11:7]
- Illegal  out  1  instruction not decodable by this stage

## Operation
- Transfer in when InValid & InReady; transfer out when OutValid & OutReady.
- Function code set: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- OP (opcode 0110011): LHS=RS1Data, RHS=RS2Data, Function={Instruction[30], funct3}. Legal only if funct7=0000000, or funct7=0100000 with funct3 000 or 101.
- OP-IMM (0010011): LHS=RS1Data, RHS=sign-extended Instruction[31:20]. Function[2:0]=funct3; Function[3]=Instruction[30] only when funct3=101, else 0. For funct3 001, funct7 must be 0000000. For funct3 101, funct7 must be 0000000 or 0100000. All other OP-IMM encodings are legal.
- Any other opcode, or an illegal funct7: Illegal=1, Function=0000, LHS=RHS=0, Rd=0. The entry is still delivered with OutValid so downstream can trap.
- Decode is combinational on the input side. Only decoded fields are stored: main register (drives outputs) plus skid register.
- Strict in-order delivery; no entry is lost or duplicated.

## Timing
- Reset: OutValid=0, InReady=1, LHS=RHS=0, Function=0000, Rd=0, Illegal=0; both entries empty.
- Latency: accept in cycle N → OutValid in cycle N+1 when main register was empty or draining.
- Throughput: one instruction per cycle while OutReady=1.
- Accept with main empty, or main draining and skid empty: new entry goes to main.
- Accept while main full and not draining: entry goes to skid. InReady=0 from the next cycle.
- Drain with skid full: main←skid, skid empty, InReady=1 next cycle. With skid full, no accept is possible because InReady=0.
- Output hold: while OutValid & !OutReady, all outputs are stable.
- InReady is a function of registered state only; there is no combinational path from OutReady.
- Reset asserted mid-operation discards both entries the next edge, regardless of handshakes.

## Configuration
- ALU_OPERAND_UPPER_EN defined: LUI (0110111) is decoded as LHS=0, RHS={Instruction[31:12],12'b0}, Function=0000. AUIPC (0010111) is decoded as LHS=PC, RHS=same immediate, Function=0000. Both are legal.
- Not defined: LUI and AUIPC are Illegal like any other unsupported opcode.

## Test plan
- ADD x3,x1,x2 (0x002081B3), RS1Data=5, RS2Data=7, OutReady=1 → next cycle OutValid=1, Function=0000, LHS=5, RHS=7, Rd=3, Illegal=0.
- SRAI x5,x6,3 (0x40335293), RS1Data=0x80000000 → Function=1101, RHS=0x00000403, Rd=5. ADDI x1,x0,-1 (0xFFF00093) → Function=0000, RHS=0xFFFFFFFF.
- Backpressure: 3 back-to-back instructions with OutReady=0 → 2 accepted, InReady=0 after the second. Raise OutReady → delivered in issue order, InReady=1 the cycle after first drain.
- Illegal: 0x0000007F, and SUB-style funct7 on OR (0x4020E1B3) → Illegal=1, Function=0000, LHS=RHS=0, delivered with OutValid.
- LUI x1,0x12345 (0x123450B7): with ALU_OPERAND_UPPER_EN → LHS=0, RHS=0x12345000, Illegal=0. Without it → Illegal=1.
- Reset pulsed with both entries full → next cycle OutValid=0, InReady=1, all outputs zero; no stale entry emerges afterward.
